inv_permute: RTL and testbench

INV_PERMUTE -- requirements
Module: inv_permute

---
 rtl/inv_permute.sv | 163 ++++++++++++++++
 tb/tb_inv_permute.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_permute.sv
// Iterated inverse of a 264-bit SPN permutation round: inverse bit permutation,
// inverse S-box layer and counter whitening, one inverse round per clock.
module inv_permute #(
    parameter int NSBOX  = 33,
    parameter int ROUNDS = 140
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NSBOX*8-1:0]   state_in,
    input  logic [15:0]          iv_in,
    output logic [NSBOX*8-1:0]   state_out,
    output logic [15:0]          iv_out,
    output logic                 busy,
    output logic                 rdy
);

    localparam int W    = NSBOX * 8;
    localparam int NNIB = NSBOX * 2;
    localparam int PMUL = NSBOX * 2;
    localparam logic [7:0] ROUNDS_C = 8'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h3;
            4'h1: y = 4'h5;
            4'h2: y = 4'h4;
            4'h3: y = 4'hE;
            4'h4: y = 4'h6;
            4'h5: y = 4'hB;
            4'h6: y = 4'hF;
            4'h7: y = 4'h8;
            4'h8: y = 4'hA;
            4'h9: y = 4'hC;
            4'hA: y = 4'h9;
            4'hB: y = 4'h2;
            4'hC: y = 4'hD;
            4'hD: y = 4'h1;
            4'hE: y = 4'h0;
            4'hF: y = 4'h7;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] bit_rev16(input logic [15:0] x);
        return {<<{x}};
    endfunction

    // Steps the LFSR one position backward, undoing the forward shift-left step.
    function automatic logic [15:0] ctr_prev(input logic [15:0] c);
        return {c[0] ^ c[15] ^ c[13] ^ c[4], c[15:1]};
    endfunction

    fsm_t          fsm_q, fsm_d;
    logic [W-1:0]  state_q, state_d;
    logic [15:0]   ctr_q, ctr_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic [W-1:0]  state_out_q, state_out_d;
    logic [15:0]   iv_out_q, iv_out_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;

    logic [W-1:0]  perm_s;
    logic [W-1:0]  sub_s;
    logic [W-1:0]  key_s;
    logic [W-1:0]  rnd_s;

    // Inverse bit permutation; the top bit is a fixed point of the permutation.
    for (genvar j = 0; j < W - 1; j++) begin : g_pinv
        localparam int SRC = (j * PMUL) % (W - 1);
        assign perm_s[j] = state_q[SRC];
    end
    assign perm_s[W-1] = state_q[W-1];

    for (genvar n = 0; n < NNIB; n++) begin : g_sbox
        assign sub_s[4*n +: 4] = inv_sbox(perm_s[4*n +: 4]);
    end

    // Whitening mask: counter at the bottom, its bit reversal at the top.
    always_comb begin
        key_s            = '0;
        key_s[15:0]      = ctr_q;
        key_s[W-1 -: 16] = bit_rev16(ctr_q);
    end

    assign rnd_s = sub_s ^ key_s;

    // Next-state and datapath control for the round sequencer.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        ctr_d       = ctr_q;
        rcnt_d      = rcnt_q;
        state_out_d = state_out_q;
        iv_out_d    = iv_out_q;
        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = state_in;
                    ctr_d   = iv_in;
                    rcnt_d  = ROUNDS_C;
                    fsm_d   = S_ROUND;
                end else begin
                    fsm_d   = S_IDLE;
                end
            end
            S_ROUND: begin
                state_d = rnd_s;
                ctr_d   = ctr_prev(ctr_q);
                rcnt_d  = rcnt_q - 8'd1;
                if (rcnt_q == 8'd1) begin
                    fsm_d       = S_DONE;
                    state_out_d = rnd_s;
                    iv_out_d    = ctr_q;
                end else begin
                    fsm_d       = S_ROUND;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        busy_d = (fsm_d == S_ROUND);
        rdy_d  = (fsm_d == S_DONE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            ctr_q       <= 16'd0;
            rcnt_q      <= 8'd0;
            state_out_q <= '0;
            iv_out_q    <= 16'd0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            rcnt_q      <= rcnt_d;
            state_out_q <= state_out_d;
            iv_out_q    <= iv_out_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
        end
    end

    assign state_out = state_out_q;
    assign iv_out    = iv_out_q;
    assign busy      = busy_q;
    assign rdy       = rdy_q;

endmodule

// File: tb/tb_inv_permute.sv
// Bench for inv_permute: round-trips random states through a forward permutation
// model and checks the recovered state, counter, latency and control behaviour.
module tb_inv_permute;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [263:0] state_in_a, state_in_b;
    logic [15:0]  iv_in_a, iv_in_b;
    logic [263:0] state_out_a, state_out_b;
    logic [15:0]  iv_out_a, iv_out_b;
    logic         busy_a, busy_b, rdy_a, rdy_b;

    int checks   = 0;
    int failures = 0;

    logic [3:0] inv_tab [16];
    logic [3:0] fwd_tab [16];

    always #5 clk = ~clk;

    inv_permute #(.NSBOX(33), .ROUNDS(140)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .state_in(state_in_a), .iv_in(iv_in_a),
        .state_out(state_out_a), .iv_out(iv_out_a), .busy(busy_a), .rdy(rdy_a)
    );

    inv_permute #(.NSBOX(33), .ROUNDS(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .state_in(state_in_b), .iv_in(iv_in_b),
        .state_out(state_out_b), .iv_out(iv_out_b), .busy(busy_b), .rdy(rdy_b)
    );

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [263:0] rand264();
        logic [263:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = {r[231:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [15:0] ctr_next(input logic [15:0] c);
        return {c[14:0], c[15] ^ c[14] ^ c[12] ^ c[3]};
    endfunction

    // Forward round: whiten with the counter, substitute, then scatter bits.
    function automatic logic [263:0] fwd_round(input logic [263:0] x, input logic [15:0] c);
        logic [263:0] t, z;
        logic [15:0]  rc;
        logic [8:0]   p, q;
        rc = {<<{c}};
        t = x;
        t[15:0]    = t[15:0] ^ c;
        t[263:248] = t[263:248] ^ rc;
        for (int n = 0; n < 66; n++) begin
            p = 9'(4 * n);
            t[p +: 4] = fwd_tab[t[p +: 4]];
        end
        z = '0;
        for (int j = 0; j < 263; j++) begin
            p = 9'((j * 66) % 263);
            q = 9'(j);
            z[p] = t[q];
        end
        z[263] = t[263];
        return z;
    endfunction

    task automatic fwd_chain(input logic [263:0] x, input logic [15:0] iv, input int n,
                             output logic [263:0] y, output logic [15:0] last);
        logic [15:0] c;
        c = iv;
        y = x;
        last = iv;
        for (int r = 0; r < n; r++) begin
            last = c;
            y = fwd_round(y, c);
            c = ctr_next(c);
        end
    endtask

    task automatic run_a(input logic [263:0] s, input logic [15:0] iv, output int lat);
        state_in_a = s;
        iv_in_a    = iv;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = 1;
        while (rdy_a !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_b(input logic [263:0] s, input logic [15:0] iv, output int lat);
        state_in_b = s;
        iv_in_b    = iv;
        start_b    = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 1;
        while (rdy_b !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        logic [263:0] x, y, xs [3], ys [3];
        logic [15:0]  iv, l, ivs [3], ls [3];
        logic [263:0] exp27;
        int lat, cyc, bad;

        inv_tab = '{4'h3, 4'h5, 4'h4, 4'hE, 4'h6, 4'hB, 4'hF, 4'h8,
                    4'hA, 4'hC, 4'h9, 4'h2, 4'hD, 4'h1, 4'h0, 4'h7};
        for (int v = 0; v < 16; v++) fwd_tab[inv_tab[v]] = 4'(v);

        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        state_in_a = '0; state_in_b = '0; iv_in_a = 16'd0; iv_in_b = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_state_out_a", state_out_a, 264'd0);
        check("reset_iv_out_a", 264'(iv_out_a), 264'd0);
        check("reset_busy_a", 264'(busy_a), 264'd0);
        check("reset_rdy_a", 264'(rdy_a), 264'd0);
        check("reset_state_out_b", state_out_b, 264'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single-round instance: known vectors.
        run_b('0, 16'h0000, lat);
        check("r1_zero_lat", 264'(lat), 264'd2);
        check("r1_zero_state", state_out_b, {66{4'h3}});
        check("r1_zero_iv", 264'(iv_out_b), 264'd0);
        @(negedge clk);
        check("r1_rdy_pulse_width", 264'(rdy_b), 264'd0);
        run_b('0, 16'h0001, lat);
        exp27 = {4'hB, {64{4'h3}}, 4'h2};
        check("r1_iv1_lat", 264'(lat), 264'd2);
        check("r1_iv1_state", state_out_b, exp27);
        check("r1_iv1_iv", 264'(iv_out_b), 264'd1);
        for (int k = 0; k < 4; k++) begin
            x = rand264();
            iv = 16'($urandom());
            fwd_chain(x, iv, 1, y, l);
            run_b(y, l, lat);
            check("r1_rand_state", state_out_b, x);
            check("r1_rand_iv", 264'(iv_out_b), 264'(iv));
        end

        // Full-length round trips; the first uses an all-zero counter.
        for (int k = 0; k < 50; k++) begin
            x = rand264();
            iv = (k == 0) ? 16'h0000 : 16'($urandom());
            fwd_chain(x, iv, 140, y, l);
            run_a(y, l, lat);
            check("rt_lat", 264'(lat), 264'd141);
            check("rt_state", state_out_a, x);
            check("rt_iv", 264'(iv_out_a), 264'(iv));
        end

        // Start re-pulsed mid-operation must be ignored.
        @(negedge clk);
        x = rand264();
        iv = 16'($urandom());
        fwd_chain(x, iv, 140, y, l);
        state_in_a = y; iv_in_a = l; start_a = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (rdy_a !== 1'b1 && cyc < 400) begin
            start_a = (cyc == 5 || cyc == 50);
            if (start_a) begin
                state_in_a = rand264();
                iv_in_a = 16'($urandom());
            end
            @(negedge clk);
            cyc++;
            if (cyc == 60) check("repulse_busy", 264'(busy_a), 264'd1);
        end
        start_a = 1'b0;
        check("repulse_lat", 264'(cyc), 264'd141);
        check("repulse_state", state_out_a, x);
        check("repulse_iv", 264'(iv_out_a), 264'(iv));
        @(negedge clk);
        check("repulse_idle_busy", 264'(busy_a), 264'd0);
        check("repulse_idle_rdy", 264'(rdy_a), 264'd0);

        // Asynchronous reset in the middle of an operation.
        x = rand264();
        iv = 16'($urandom());
        fwd_chain(x, iv, 140, y, l);
        state_in_a = y; iv_in_a = l; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (69) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_state_out", state_out_a, 264'd0);
        check("midrst_iv_out", 264'(iv_out_a), 264'd0);
        check("midrst_busy", 264'(busy_a), 264'd0);
        check("midrst_rdy", 264'(rdy_a), 264'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (rdy_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        check("midrst_no_rdy", 264'(bad), 264'd0);
        run_a(y, l, lat);
        check("postrst_lat", 264'(lat), 264'd141);
        check("postrst_state", state_out_a, x);
        check("postrst_iv", 264'(iv_out_a), 264'(iv));

        // Start held high: back-to-back operations, each on its own input.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            xs[k] = rand264();
            ivs[k] = 16'($urandom());
            fwd_chain(xs[k], ivs[k], 140, ys[k], ls[k]);
        end
        state_in_a = ys[0]; iv_in_a = ls[0]; start_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (lat == 1) begin
                    state_in_a = rand264();
                    iv_in_a = 16'($urandom());
                end
            end while (rdy_a !== 1'b1 && lat < 400);
            check("held_lat", 264'(lat), 264'd141);
            check("held_state", state_out_a, xs[k]);
            check("held_iv", 264'(iv_out_a), 264'(ivs[k]));
            if (k < 2) begin
                state_in_a = ys[k+1];
                iv_in_a = ls[k+1];
            end else begin
                start_a = 1'b0;
            end
        end
        @(negedge clk);
        check("held_end_busy", 264'(busy_a), 264'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
